cpu_run_ctrl: RTL

//  Run sequencer for the 9-bit-ISA core. Accepts a go request with a program select.

---
 rtl/cpu_run_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
//   Run sequencer for the 9-bit-ISA core. On an accepted go it pulses the core
//   reset for one cycle, holds core_start for START_CYC cycles, then lets the
//   core run. It counts run cycles until core_done, or stops after TIMEOUT
//   cycles, and reports completion with a one-cycle finished pulse.
//
//   Optional feature macro: RUN_CTRL_ABORT_EN adds the abort input.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   go          in   run request, sampled only while idle
//   prog_sel    in   program select 0..2 (3 is invalid)
//   core_done   in   done level from the core
//   core_reset  out  reset to the core (also high while reset is high)
//   core_start  out  start strobe to the core, high during the start window
//   entry_pc    out  base PC of the latched program
//   busy        out  high whenever a run is in progress
//   finished    out  one-cycle pulse at the end of a run
//   timed_out   out  sticky timeout flag, cleared by the next accepted go
//   cycle_count out  run cycles counted for the current/last run
//   abort       in   (RUN_CTRL_ABORT_EN only) stop the current run
// -----------------------------------------------------------------------------
module cpu_run_ctrl #(
   parameter int          D         = 10,
   parameter int          CW        = 16,
   parameter int          START_CYC = 2,
   parameter int unsigned TIMEOUT   = 32'h0000_0FFF,
   parameter int unsigned P0_BASE   = 0,
   parameter int unsigned P1_BASE   = 166,
   parameter int unsigned P2_BASE   = 450
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          go,
   input  logic [1:0]    prog_sel,
   input  logic          core_done,
   output logic          core_reset,
   output logic          core_start,
   output logic [D-1:0]  entry_pc,
   output logic          busy,
   output logic          finished,
   output logic          timed_out,
   output logic [CW-1:0] cycle_count
`ifdef RUN_CTRL_ABORT_EN
   ,
   input  logic          abort
`endif
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CRST  = 3'd1,
      START = 3'd2,
      RUN   = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t     state, nextState;
   logic [1:0] selReg;
   logic [3:0] startCnt;
   logic       acceptGo;
   logic       incCount;
   logic       setTimeout;
   logic       abortReq;

`ifdef RUN_CTRL_ABORT_EN
   assign abortReq = abort;
`else
   assign abortReq = 1'b0;
`endif

   // State register plus run bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         selReg      <= 2'd0;
         startCnt    <= 4'd0;
         cycle_count <= '0;
         timed_out   <= 1'b0;
      end else begin
         state <= nextState;
         // startCnt only advances inside the start window; zero elsewhere so
         // each window begins counting from 0.
         startCnt <= (state == START) ? startCnt + 4'd1 : 4'd0;
         if (acceptGo) begin
            selReg      <= prog_sel;
            cycle_count <= '0;
            timed_out   <= 1'b0;
         end
         if (incCount)
            cycle_count <= cycle_count + 1'b1;
         if (setTimeout)
            timed_out <= 1'b1;
      end
   end

   // Next-state and per-cycle control
   always_comb begin
      nextState  = state;
      acceptGo   = 1'b0;
      incCount   = 1'b0;
      setTimeout = 1'b0;
      case (state)
         IDLE: begin
            if (go && (prog_sel != 2'd3)) begin
               acceptGo  = 1'b1;
               nextState = CRST;
            end
         end
         CRST: nextState = START;
         START: begin
            // core_done is deliberately not looked at during the start window.
            if (abortReq)
               nextState = FIN;
            else if (startCnt == 4'(START_CYC - 1))
               nextState = RUN;
         end
         RUN: begin
            // Priority: abort, then done, then timeout; done in the timeout
            // cycle therefore leaves timed_out clear.
            if (abortReq || core_done)
               nextState = FIN;
            else if (cycle_count == CW'(TIMEOUT)) begin
               setTimeout = 1'b1;
               nextState  = FIN;
            end else
               incCount = 1'b1;
         end
         FIN:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   assign core_reset = reset | (state == CRST);
   assign core_start = (state == START);
   assign busy       = (state != IDLE);
   assign finished   = (state == FIN);

   always_comb begin
      case (selReg)
         2'd1:    entry_pc = D'(P1_BASE);
         2'd2:    entry_pc = D'(P2_BASE);
         default: entry_pc = D'(P0_BASE);
      endcase
   end

endmodule
